// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction-fetch front end.
//   INSTR_W      : instruction word width
//   PC_W         : width of the PC field stored in a queue entry
//   RESET_PC_DEF : default first fetch address after reset
//   PC_INC       : sequential PC step (one 32-bit word)
//   fetch_entry_t: prefetch queue entry {pc, instr}
//   fetch_state_t: fetch control state {ST_IDLE, ST_RUN}
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;
    localparam int PC_INC  = 4;

    localparam logic [PC_W-1:0] RESET_PC_DEF = 32'h0000_0000;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    localparam fetch_entry_t ENTRY_ZERO = '{pc: 32'h0000_0000, instr: 32'h0000_0000};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Synchronous DEPTH-entry prefetch queue holding {pc, instr} entries.
// Ports:
//   clk    : clock, rising edge
//   rst    : asynchronous active-low reset
//   push   : enqueue din (ignored during flush)
//   din    : entry to enqueue
//   pop    : decode wants to consume the head
//   flush  : discard all entries; has priority over push
//   pop_ok : pop accepted this cycle (head was valid)
//   count  : current occupancy
//   head   : registered head entry; keeps its last value when empty
// -----------------------------------------------------------------------------
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  fetch_entry_t       din,
    input  logic               pop,
    input  logic               flush,
    output logic               pop_ok,
    output logic [CNT_W-1:0]   count,
    output fetch_entry_t       head
);

    fetch_entry_t       mem_r [DEPTH];
    fetch_entry_t       head_r;
    fetch_entry_t       head_next_s;
    logic [PTR_W-1:0]   rd_r;
    logic [PTR_W-1:0]   wr_r;
    logic [PTR_W-1:0]   rd_next_s;
    logic [PTR_W-1:0]   wr_next_s;
    logic [CNT_W-1:0]   count_r;
    logic [CNT_W-1:0]   count_next_s;
    logic               pop_ok_s;
    logic               push_ok_s;

    // Next-state of pointers, occupancy and the registered head copy
    always_comb begin
        pop_ok_s  = pop & (count_r != {CNT_W{1'b0}});
        // A full queue can still take a push when the head leaves in the same cycle
        push_ok_s = push & ~flush & ((count_r != CNT_W'(DEPTH)) | pop_ok_s);

        if (flush) begin
            count_next_s = {CNT_W{1'b0}};
            rd_next_s    = wr_r;
            wr_next_s    = wr_r;
        end else begin
            count_next_s = count_r + CNT_W'(push_ok_s) - CNT_W'(pop_ok_s);
            rd_next_s    = rd_r + PTR_W'(pop_ok_s);
            wr_next_s    = wr_r + PTR_W'(push_ok_s);
        end

        // The head register mirrors mem[rd] whenever the queue is non-empty, so
        // a word written this cycle into the new head slot is bypassed from din.
        head_next_s = head_r;
        if (count_next_s == {CNT_W{1'b0}}) begin
            head_next_s = head_r;
        end else if (push_ok_s && (rd_next_s == wr_r)) begin
            head_next_s = din;
        end else begin
            head_next_s = mem_r[rd_next_s];
        end
    end

    // Storage, pointers, occupancy and head registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= ENTRY_ZERO;
            end
            head_r  <= ENTRY_ZERO;
            rd_r    <= {PTR_W{1'b0}};
            wr_r    <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wr_r] <= din;
            end
            head_r  <= head_next_s;
            rd_r    <= rd_next_s;
            wr_r    <= wr_next_s;
            count_r <= count_next_s;
        end
    end

    assign pop_ok = pop_ok_s;
    assign count  = count_r;
    assign head   = head_r;

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch front end: generates the fetch PC, issues reads to a
// synchronous instruction memory (1-cycle latency), buffers returned words in
// a prefetch queue and presents them to decode over valid/ready.
// Ports:
//   clk            : clock, rising edge
//   rst            : asynchronous active-low reset
//   start          : fetching allowed while high
//   imem_req       : instruction memory read strobe
//   imem_addr      : word-aligned read address
//   imem_rdata     : read data, valid the cycle after imem_req
//   redirect_valid : branch/jump taken pulse (flushes queue, kills in-flight)
//   redirect_pc    : redirect target, low two bits ignored
//   dec_valid      : queue head valid
//   dec_ready      : decode accepts head
//   dec_instr      : head instruction
//   dec_pc         : PC of head instruction
//   PC_out         : next address to be requested
// -----------------------------------------------------------------------------
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
    parameter int                DEPTH    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                imem_req,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic [INSTR_W-1:0]  imem_rdata,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_pc,
    output logic                dec_valid,
    input  logic                dec_ready,
    output logic [INSTR_W-1:0]  dec_instr,
    output logic [ADDR_W-1:0]   dec_pc,
    output logic [ADDR_W-1:0]   PC_out
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int OCC_W = CNT_W + 1;

    fetch_state_t        state_r;
    fetch_state_t        state_next_s;
    logic [ADDR_W-1:0]   pc_r;
    logic [ADDR_W-1:0]   pc_next_s;
    logic [ADDR_W-1:0]   resp_pc_r;
    logic [ADDR_W-1:0]   redir_pc_s;
    logic                inflight_r;
    logic                issue_s;
    logic                pop_s;
    logic [CNT_W-1:0]    count_s;
    logic [OCC_W-1:0]    occ_s;
    logic [OCC_W-1:0]    lim_s;
    fetch_entry_t        push_entry_s;
    fetch_entry_t        head_s;

    // Run/idle control follows the start level
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!start) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Issue decision and next fetch PC
    always_comb begin
        // Credit check: queued + in-flight words after this cycle's pop must
        // leave room for one more, so the queue can never overflow.
        occ_s = OCC_W'(count_s) + OCC_W'(inflight_r);
        lim_s = OCC_W'(DEPTH) + OCC_W'(pop_s);

        if ((state_r == ST_RUN) && !redirect_valid && (occ_s < lim_s)) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end

        redir_pc_s = redirect_pc & {{(ADDR_W-2){1'b1}}, 2'b00};

        if (redirect_valid) begin
            pc_next_s = redir_pc_s;
        end else if (issue_s) begin
            pc_next_s = pc_r + ADDR_W'(PC_INC);   // wraps naturally at the top
        end else begin
            pc_next_s = pc_r;
        end
    end

    // Control state, fetch PC and in-flight tracking
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            pc_r       <= RESET_PC;
            resp_pc_r  <= RESET_PC;
            inflight_r <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            pc_r       <= pc_next_s;
            inflight_r <= issue_s;
            if (issue_s) begin
                resp_pc_r <= pc_r;
            end else begin
                resp_pc_r <= resp_pc_r;
            end
        end
    end

    // Returning word paired with the address that requested it
    always_comb begin
        push_entry_s       = ENTRY_ZERO;
        push_entry_s.pc    = PC_W'(resp_pc_r);
        push_entry_s.instr = imem_rdata;
    end

    // A redirect flushes the queue and, by flush priority, kills the
    // response arriving in the same cycle.
    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (inflight_r),
        .din    (push_entry_s),
        .pop    (dec_ready),
        .flush  (redirect_valid),
        .pop_ok (pop_s),
        .count  (count_s),
        .head   (head_s)
    );

    assign imem_req  = issue_s;
    assign imem_addr = pc_r;
    assign PC_out    = pc_r;
    assign dec_valid = (count_s != {CNT_W{1'b0}});
    assign dec_instr = head_s.instr;
    assign dec_pc    = ADDR_W'(head_s.pc);

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Directed bench for fetch_stage. The instruction memory model returns
// addr ^ 32'hA5A5_0000 one cycle after a request. Inputs are driven 2 time
// units after the rising edge and outputs are sampled 1 unit later.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0000_0000;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic [31:0] PC_out;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_pc;

    fetch_stage #(
        .ADDR_W   (32),
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc),
        .PC_out         (PC_out)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory model
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= imem_addr ^ KEY;
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; dec_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0000_0000;
        #3;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", imem_req); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
        total++; if (PC_out !== 32'h0) begin bad++; $display("FAIL rst_pc_out: got %h want 0", PC_out); end
        total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL rst_dec_valid: got %b want 0", dec_valid); end
        total++; if (dec_instr !== 32'h0) begin bad++; $display("FAIL rst_dec_instr: got %h want 0", dec_instr); end
        total++; if (dec_pc !== 32'h0) begin bad++; $display("FAIL rst_dec_pc: got %h want 0", dec_pc); end
        cyc();
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc(); #1;
            total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL idle_req c%0d: got %b want 0", i, imem_req); end
            total++; if (PC_out !== 32'h0) begin bad++; $display("FAIL idle_pc c%0d: got %h want 0", i, PC_out); end
            total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL idle_valid c%0d: got %b want 0", i, dec_valid); end
        end
    endtask

    task automatic test_latency();
        start = 1'b1;
        cyc(); #1;
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL lat_req0: got %b want 1", imem_req); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL lat_addr0: got %h want 0", imem_addr); end
        cyc(); #1;
        total++; if (imem_addr !== 32'h4 || imem_req !== 1'b1) begin bad++; $display("FAIL lat_req1: got req=%b addr=%h want req=1 addr=4", imem_req, imem_addr); end
        total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL lat_early_valid: got %b want 0", dec_valid); end
        cyc(); #1;
        total++; if (dec_valid !== 1'b1) begin bad++; $display("FAIL lat_valid: got %b want 1", dec_valid); end
        total++; if (dec_pc !== 32'h0) begin bad++; $display("FAIL lat_dec_pc: got %h want 0", dec_pc); end
        total++; if (dec_instr !== 32'hA5A5_0000) begin bad++; $display("FAIL lat_dec_instr: got %h want a5a50000", dec_instr); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL lat_credit: got %b want 0", imem_req); end
    endtask

    task automatic test_stream();
        dec_ready = 1'b1;
        #1;
        exp_pc = 32'h0;
        for (int i = 0; i < 20; i++) begin
            total++; if (dec_valid !== 1'b1) begin bad++; $display("FAIL stream_valid c%0d: got %b want 1", i, dec_valid); end
            total++; if (dec_pc !== exp_pc) begin bad++; $display("FAIL stream_pc c%0d: got %h want %h", i, dec_pc, exp_pc); end
            total++; if (dec_instr !== (exp_pc ^ KEY)) begin bad++; $display("FAIL stream_instr c%0d: got %h want %h", i, dec_instr, exp_pc ^ KEY); end
            total++; if (imem_req !== 1'b1 || imem_addr !== exp_pc + 32'd8) begin bad++; $display("FAIL stream_req c%0d: got req=%b addr=%h want req=1 addr=%h", i, imem_req, imem_addr, exp_pc + 32'd8); end
            exp_pc = exp_pc + 32'd4;
            cyc(); #1;
        end
    endtask

    task automatic test_stall();
        dec_ready = 1'b0;
        #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL stall_req_now: got %b want 0", imem_req); end
        for (int i = 0; i < 8; i++) begin
            cyc(); #1;
            total++; if (dec_valid !== 1'b1 || dec_pc !== 32'h50) begin bad++; $display("FAIL stall_head c%0d: got v=%b pc=%h want v=1 pc=50", i, dec_valid, dec_pc); end
            total++; if (dec_instr !== (32'h50 ^ KEY)) begin bad++; $display("FAIL stall_instr c%0d: got %h want %h", i, dec_instr, 32'h50 ^ KEY); end
            total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL stall_req c%0d: got %b want 0", i, imem_req); end
            total++; if (PC_out !== 32'h58) begin bad++; $display("FAIL stall_pc_out c%0d: got %h want 58", i, PC_out); end
        end
        dec_ready = 1'b1;
        #1;
        for (int i = 0; i < 6; i++) begin
            total++; if (dec_valid !== 1'b1 || dec_pc !== exp_pc) begin bad++; $display("FAIL resume_pc c%0d: got v=%b pc=%h want v=1 pc=%h", i, dec_valid, dec_pc, exp_pc); end
            total++; if (dec_instr !== (exp_pc ^ KEY)) begin bad++; $display("FAIL resume_instr c%0d: got %h want %h", i, dec_instr, exp_pc ^ KEY); end
            exp_pc = exp_pc + 32'd4;
            cyc(); #1;
        end
    endtask

    task automatic test_redirect();
        // one word queued and one in flight: both credits used
        dec_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
        #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL redir_req_now: got %b want 0", imem_req); end
        cyc();
        redirect_valid = 1'b0;
        #1;
        total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL redir_flush: got %b want 0", dec_valid); end
        total++; if (PC_out !== 32'h100) begin bad++; $display("FAIL redir_pc_out: got %h want 100", PC_out); end
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin bad++; $display("FAIL redir_req0: got req=%b addr=%h want req=1 addr=100", imem_req, imem_addr); end
        cyc(); #1;
        total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL redir_killed: got %b want 0", dec_valid); end
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h104) begin bad++; $display("FAIL redir_req1: got req=%b addr=%h want req=1 addr=104", imem_req, imem_addr); end
        cyc(); #1;
        total++; if (dec_valid !== 1'b1 || dec_pc !== 32'h100) begin bad++; $display("FAIL redir_first: got v=%b pc=%h want v=1 pc=100", dec_valid, dec_pc); end
        total++; if (dec_instr !== 32'hA5A5_0100) begin bad++; $display("FAIL redir_instr: got %h want a5a50100", dec_instr); end
        exp_pc = 32'h100;
        dec_ready = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            total++; if (dec_valid !== 1'b1 || dec_pc !== exp_pc) begin bad++; $display("FAIL redir_stream c%0d: got v=%b pc=%h want v=1 pc=%h", i, dec_valid, dec_pc, exp_pc); end
            exp_pc = exp_pc + 32'd4;
            cyc(); #1;
        end
    endtask

    task automatic test_wrap();
        // decode still accepts the head during the redirect cycle
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL wrap_req_now: got %b want 0", imem_req); end
        cyc();
        redirect_valid = 1'b0;
        #1;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFF8) begin bad++; $display("FAIL wrap_a0: got req=%b addr=%h want req=1 addr=fffffff8", imem_req, imem_addr); end
        total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL wrap_flush: got %b want 0", dec_valid); end
        cyc(); #1;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_a1: got req=%b addr=%h want req=1 addr=fffffffc", imem_req, imem_addr); end
        cyc(); #1;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL wrap_a2: got req=%b addr=%h want req=1 addr=0", imem_req, imem_addr); end
        total++; if (dec_valid !== 1'b1 || dec_pc !== 32'hFFFF_FFF8) begin bad++; $display("FAIL wrap_d0: got v=%b pc=%h want v=1 pc=fffffff8", dec_valid, dec_pc); end
        cyc(); #1;
        total++; if (dec_valid !== 1'b1 || dec_pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_d1: got v=%b pc=%h want v=1 pc=fffffffc", dec_valid, dec_pc); end
        cyc(); #1;
        total++; if (dec_valid !== 1'b1 || dec_pc !== 32'h0) begin bad++; $display("FAIL wrap_d2: got v=%b pc=%h want v=1 pc=0", dec_valid, dec_pc); end
        total++; if (dec_instr !== KEY) begin bad++; $display("FAIL wrap_i2: got %h want %h", dec_instr, KEY); end
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin bad++; $display("FAIL wrap_a4: got req=%b addr=%h want req=1 addr=8", imem_req, imem_addr); end
    endtask

    task automatic test_idle();
        // head pc 0, pc 4 in flight, PC_out 8
        start = 1'b0; dec_ready = 1'b0;
        #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL idle2_req_now: got %b want 0", imem_req); end
        for (int i = 0; i < 4; i++) begin
            cyc(); #1;
            total++; if (imem_req !== 1'b0 || PC_out !== 32'h8) begin bad++; $display("FAIL idle2_hold c%0d: got req=%b pc_out=%h want req=0 pc_out=8", i, imem_req, PC_out); end
            total++; if (dec_valid !== 1'b1 || dec_pc !== 32'h0) begin bad++; $display("FAIL idle2_head c%0d: got v=%b pc=%h want v=1 pc=0", i, dec_valid, dec_pc); end
        end
        dec_ready = 1'b1;
        cyc(); #1;
        total++; if (dec_valid !== 1'b1 || dec_pc !== 32'h4) begin bad++; $display("FAIL idle2_inflight: got v=%b pc=%h want v=1 pc=4", dec_valid, dec_pc); end
        cyc(); #1;
        total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL idle2_empty: got %b want 0", dec_valid); end
        total++; if (dec_pc !== 32'h4 || dec_instr !== (32'h4 ^ KEY)) begin bad++; $display("FAIL idle2_keep: got pc=%h instr=%h want pc=4 instr=%h", dec_pc, dec_instr, 32'h4 ^ KEY); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL idle2_noreq: got %b want 0", imem_req); end
        start = 1'b1;
        cyc(); #1;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin bad++; $display("FAIL idle2_restart: got req=%b addr=%h want req=1 addr=8", imem_req, imem_addr); end
    endtask

    task automatic test_async_reset();
        cyc(); #1;
        cyc(); #1;
        #3;
        rst = 1'b0;
        #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL arst_req: got %b want 0", imem_req); end
        total++; if (imem_addr !== 32'h0 || PC_out !== 32'h0) begin bad++; $display("FAIL arst_pc: got addr=%h pc_out=%h want 0", imem_addr, PC_out); end
        total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL arst_valid: got %b want 0", dec_valid); end
        total++; if (dec_instr !== 32'h0 || dec_pc !== 32'h0) begin bad++; $display("FAIL arst_dec: got instr=%h pc=%h want 0", dec_instr, dec_pc); end
        cyc();
        rst = 1'b1;
        #1;
        total++; if (imem_req !== 1'b0 || dec_valid !== 1'b0) begin bad++; $display("FAIL arst_rel: got req=%b v=%b want 0 0", imem_req, dec_valid); end
        cyc(); #1;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL arst_req0: got req=%b addr=%h want req=1 addr=0", imem_req, imem_addr); end
        total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL arst_stale: got %b want 0", dec_valid); end
        cyc(); #1;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin bad++; $display("FAIL arst_req1: got req=%b addr=%h want req=1 addr=4", imem_req, imem_addr); end
        cyc(); #1;
        total++; if (dec_valid !== 1'b1 || dec_pc !== 32'h0) begin bad++; $display("FAIL arst_first: got v=%b pc=%h want v=1 pc=0", dec_valid, dec_pc); end
        total++; if (dec_instr !== KEY) begin bad++; $display("FAIL arst_instr: got %h want %h", dec_instr, KEY); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_stream();
        test_stall();
        test_redirect();
        test_wrap();
        test_idle();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
